// File: rtl/uart_duplex_pkg.sv
// rtl/uart_duplex_pkg.sv - shared FSM state encoding and rxerr bit positions (parity option: UART_PARITY_EN)
package uart_duplex_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int ERR_FRAMING = 0;
    localparam int ERR_OVERRUN = 1;
    localparam int ERR_PARITY  = 2;

endpackage

// File: rtl/uart_duplex_rx.sv
// rtl/uart_duplex_rx.sv - rx pin synchroniser, receive FSM and client word register (parity option: UART_PARITY_EN)
module uart_duplex_rx
    import uart_duplex_pkg::*;
#(
    parameter int INT      = 10,
    parameter int DATABITS = 8,
    parameter int PAR_ODD  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    input  logic                rxack,
    output logic                rxreq,
    output logic [DATABITS-1:0] rxdata,
    output logic [2:0]          rxerr
);

    localparam int TW = $clog2(INT) + 1;
    localparam int BW = $clog2(DATABITS + 1);

    logic                rx_s1, rx_s2, rx_prev;
    uart_state_t         state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [BW-1:0]       bits_q, bits_d;
    logic [DATABITS-1:0] shift_q, shift_d;
    logic                done;
    logic                frame_err;
    logic                par_err;
`ifdef UART_PARITY_EN
    logic                par_err_q, par_err_d;
    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    // Two-flop synchroniser plus one delayed copy for start-edge detection; idles high.
    // A line held low never produces a new falling edge, so a break re-arms only after rx returns to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Receive FSM state, bit timer, bit counter and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            bits_q  <= '0;
            shift_q <= '0;
`ifdef UART_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
`ifdef UART_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    // Next-state logic: start check at half a bit, then one mid-bit sample per INT cycles.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bits_d    = bits_q;
        shift_d   = shift_q;
        done      = 1'b0;
        frame_err = 1'b0;
`ifdef UART_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_prev && !rx_s2) begin
                    state_d = ST_START;
                    timer_d = TW'(INT / 2 - 1);
                end
            end
            ST_START: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (rx_s2) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                    timer_d = TW'(INT - 1);
                    bits_d  = '0;
                end
            end
            ST_DATA: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    shift_d = {rx_s2, shift_q[DATABITS-1:1]};
                    bits_d  = bits_q + BW'(1);
                    timer_d = TW'(INT - 1);
                    if (bits_q == BW'(DATABITS - 1)) begin
`ifdef UART_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    par_err_d = rx_s2 ^ (^shift_q) ^ PAR_ODD[0];
                    state_d   = ST_STOP;
                    timer_d   = TW'(INT - 1);
                end
            end
`endif
            ST_STOP: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    done      = 1'b1;
                    frame_err = !rx_s2;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Client word register: a completing frame beats a same-cycle rxack; an unread word is kept on overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxreq  <= 1'b0;
            rxdata <= '0;
            rxerr  <= '0;
        end else if (done) begin
            if (rxreq && !rxack) begin
                rxerr[ERR_OVERRUN] <= 1'b1;
            end else begin
                rxreq  <= 1'b1;
                rxdata <= shift_q;
                rxerr  <= {par_err, 1'b0, frame_err};
            end
        end else if (rxack) begin
            rxreq <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_duplex.sv
// rtl/uart_duplex.sv - full-duplex UART top: inline transmitter plus uart_duplex_rx (parity option: UART_PARITY_EN)
module uart_duplex
    import uart_duplex_pkg::*;
#(
    parameter int SYSHZ    = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int DATABITS = 8,
    parameter int STOPBITS = 1,
    parameter int PAR_ODD  = 0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                tx,
    input  logic                rx,
    input  logic                txreq,
    output logic                txack,
    input  logic [DATABITS-1:0] txdata,
    output logic                rxreq,
    input  logic                rxack,
    output logic [DATABITS-1:0] rxdata,
    output logic [2:0]          rxerr
);

    localparam int INT      = SYSHZ / BAUD;
    localparam int TW       = $clog2(INT) + 1;
    localparam int BW       = $clog2(DATABITS + 1);
    localparam int STOP_LEN = STOPBITS * INT;

    uart_state_t         tx_state_q, tx_state_d;
    logic [TW-1:0]       tx_timer_q, tx_timer_d;
    logic [BW-1:0]       tx_bits_q, tx_bits_d;
    logic [DATABITS-1:0] tx_shift_q, tx_shift_d;
    logic                tx_q, tx_d;
    logic                txack_q, txack_d;
`ifdef UART_PARITY_EN
    logic                tx_par_q, tx_par_d;
`endif

    assign tx    = tx_q;
    assign txack = txack_q;

    // Transmit FSM registers; the line output is registered so tx is glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= ST_IDLE;
            tx_timer_q <= '0;
            tx_bits_q  <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            txack_q    <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_timer_q <= tx_timer_d;
            tx_bits_q  <= tx_bits_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            txack_q    <= txack_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    // Next-state logic: each state holds its line level for one timer run, then moves on.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_timer_d = tx_timer_q;
        tx_bits_d  = tx_bits_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        txack_d    = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            ST_IDLE: begin
                if (txreq) begin
                    tx_state_d = ST_START;
                    tx_timer_d = TW'(INT - 1);
                    tx_shift_d = txdata;
                    tx_d       = 1'b0;
`ifdef UART_PARITY_EN
                    tx_par_d   = (^txdata) ^ PAR_ODD[0];
`endif
                end
            end
            ST_START: begin
                if (tx_timer_q != '0) begin
                    tx_timer_d = tx_timer_q - TW'(1);
                end else begin
                    tx_state_d = ST_DATA;
                    tx_timer_d = TW'(INT - 1);
                    tx_bits_d  = BW'(DATABITS - 1);
                    tx_d       = tx_shift_q[0];
                end
            end
            ST_DATA: begin
                if (tx_timer_q != '0) begin
                    tx_timer_d = tx_timer_q - TW'(1);
                end else if (tx_bits_q != '0) begin
                    tx_timer_d = TW'(INT - 1);
                    tx_bits_d  = tx_bits_q - BW'(1);
                    tx_shift_d = tx_shift_q >> 1;
                    tx_d       = tx_shift_q[1];
                end else begin
`ifdef UART_PARITY_EN
                    tx_state_d = ST_PARITY;
                    tx_timer_d = TW'(INT - 1);
                    tx_d       = tx_par_q;
`else
                    tx_state_d = ST_STOP;
                    tx_timer_d = TW'(STOP_LEN - 1);
                    tx_d       = 1'b1;
`endif
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (tx_timer_q != '0) begin
                    tx_timer_d = tx_timer_q - TW'(1);
                end else begin
                    tx_state_d = ST_STOP;
                    tx_timer_d = TW'(STOP_LEN - 1);
                    tx_d       = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (tx_timer_q != '0) begin
                    tx_timer_d = tx_timer_q - TW'(1);
                end else begin
                    tx_state_d = ST_IDLE;
                    txack_d    = 1'b1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    uart_duplex_rx #(
        .INT      (INT),
        .DATABITS (DATABITS),
        .PAR_ODD  (PAR_ODD)
    ) u_rx (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .rxack  (rxack),
        .rxreq  (rxreq),
        .rxdata (rxdata),
        .rxerr  (rxerr)
    );

endmodule
